// File: rtl/block_1_indirect_access_ctrl_if.sv
// Request/response and APB signal bundle for block_1_indirect_access_ctrl.
// slave = controller view; master = requester plus APB-slave view.
interface block_1_indirect_access_ctrl_if #(
    parameter int unsigned ADDRESS_WIDTH = 7
);
    logic                     i_req_valid;
    logic                     o_req_ready;
    logic                     i_req_write;
    logic [7:0]               i_req_index0;
    logic [7:0]               i_req_index1;
    logic [31:0]              i_req_wdata;
    logic                     o_rsp_valid;
    logic                     i_rsp_ready;
    logic [31:0]              o_rsp_rdata;
    logic [1:0]               o_rsp_status;
    logic                     o_psel;
    logic                     o_penable;
    logic [ADDRESS_WIDTH-1:0] o_paddr;
    logic                     o_pwrite;
    logic [31:0]              o_pwdata;
    logic [3:0]               o_pstrb;
    logic                     i_pready;
    logic [31:0]              i_prdata;
    logic                     i_pslverr;

    modport slave (
        input  i_req_valid, i_req_write, i_req_index0, i_req_index1, i_req_wdata,
        input  i_rsp_ready, i_pready, i_prdata, i_pslverr,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_status,
        output o_psel, o_penable, o_paddr, o_pwrite, o_pwdata, o_pstrb
    );

    modport master (
        output i_req_valid, i_req_write, i_req_index0, i_req_index1, i_req_wdata,
        output i_rsp_ready, i_pready, i_prdata, i_pslverr,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_status,
        input  o_psel, o_penable, o_paddr, o_pwrite, o_pwdata, o_pstrb
    );
endinterface

// File: rtl/block_1_indirect_access_ctrl.sv
// APB master sequencing index0/index1/data indirect accesses into block_1.
// Optional index cache: define BLOCK1_INDIRECT_INDEX_CACHE_EN.
module block_1_indirect_access_ctrl #(
    parameter int unsigned              ADDRESS_WIDTH = 7,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS  = '0,
    parameter logic [ADDRESS_WIDTH-1:0] INDEX0_OFFSET = ADDRESS_WIDTH'(7'h00),
    parameter logic [ADDRESS_WIDTH-1:0] INDEX1_OFFSET = ADDRESS_WIDTH'(7'h04),
    parameter logic [ADDRESS_WIDTH-1:0] DATA_OFFSET   = ADDRESS_WIDTH'(7'h10),
    parameter int unsigned              TIMEOUT       = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    block_1_indirect_access_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [ADDRESS_WIDTH-1:0] IX0_ADDR = ADDRESS_WIDTH'(BASE_ADDRESS + INDEX0_OFFSET);
    localparam logic [ADDRESS_WIDTH-1:0] IX1_ADDR = ADDRESS_WIDTH'(BASE_ADDRESS + INDEX1_OFFSET);
    localparam logic [ADDRESS_WIDTH-1:0] DAT_ADDR = ADDRESS_WIDTH'(BASE_ADDRESS + DATA_OFFSET);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_IX0_SETUP  = 3'd1;
    localparam logic [2:0] S_IX0_ACCESS = 3'd2;
    localparam logic [2:0] S_IX1_SETUP  = 3'd3;
    localparam logic [2:0] S_IX1_ACCESS = 3'd4;
    localparam logic [2:0] S_DAT_SETUP  = 3'd5;
    localparam logic [2:0] S_DAT_ACCESS = 3'd6;
    localparam logic [2:0] S_RESP       = 3'd7;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_SLVERR  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    logic [2:0]               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     req_write_q, req_write_d;
    logic [7:0]               index0_q, index0_d;
    logic [7:0]               index1_q, index1_d;
    logic [31:0]              wdata_q, wdata_d;
    logic                     req_ready_q, req_ready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [31:0]              rsp_rdata_q, rsp_rdata_d;
    logic [1:0]               rsp_status_q, rsp_status_d;
    logic                     psel_q, psel_d;
    logic                     penable_q, penable_d;
    logic [ADDRESS_WIDTH-1:0] paddr_q, paddr_d;
    logic                     pwrite_q, pwrite_d;
    logic [31:0]              pwdata_q, pwdata_d;
    logic [3:0]               pstrb_q, pstrb_d;

    logic in_access;
    logic done_ok;
    logic abort;
    logic hit0;
    logic hit1;
    logic skip1;

`ifdef BLOCK1_INDIRECT_INDEX_CACHE_EN
    logic       c0_valid_q, c0_valid_d;
    logic       c1_valid_q, c1_valid_d;
    logic [7:0] c0_q, c0_d;
    logic [7:0] c1_q, c1_d;
    logic       skip1_q, skip1_d;

    assign hit0  = c0_valid_q && (c0_q == bus.i_req_index0);
    assign hit1  = c1_valid_q && (c1_q == bus.i_req_index1);
    assign skip1 = skip1_q;
`else
    assign hit0  = 1'b0;
    assign hit1  = 1'b0;
    assign skip1 = 1'b0;
`endif

    // Access-phase outcome: clean completion, or error/timeout aborting the sequence.
    assign in_access = (state_q == S_IX0_ACCESS) || (state_q == S_IX1_ACCESS) ||
                       (state_q == S_DAT_ACCESS);
    assign done_ok   = in_access && bus.i_pready && !bus.i_pslverr;
    assign abort     = in_access && ((bus.i_pready && bus.i_pslverr) ||
                                     (!bus.i_pready && (cnt_q == CNT_LAST)));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_write_d  = req_write_q;
        index0_d     = index0_q;
        index1_d     = index1_q;
        wdata_d      = wdata_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_status_d = rsp_status_q;
`ifdef BLOCK1_INDIRECT_INDEX_CACHE_EN
        c0_valid_d   = c0_valid_q;
        c1_valid_d   = c1_valid_q;
        c0_d         = c0_q;
        c1_d         = c1_q;
        skip1_d      = skip1_q;
`endif

        if (abort) begin
            state_d      = S_RESP;
            rsp_rdata_d  = '0;
            rsp_status_d = bus.i_pready ? ST_SLVERR : ST_TIMEOUT;
`ifdef BLOCK1_INDIRECT_INDEX_CACHE_EN
            c0_valid_d   = 1'b0;
            c1_valid_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.i_req_valid && req_ready_q) begin
                        req_write_d = bus.i_req_write;
                        index0_d    = bus.i_req_index0;
                        index1_d    = bus.i_req_index1;
                        wdata_d     = bus.i_req_wdata;
`ifdef BLOCK1_INDIRECT_INDEX_CACHE_EN
                        skip1_d     = hit1;
`endif
                        if (!hit0)      state_d = S_IX0_SETUP;
                        else if (!hit1) state_d = S_IX1_SETUP;
                        else            state_d = S_DAT_SETUP;
                    end
                end
                S_IX0_SETUP: begin
                    state_d = S_IX0_ACCESS;
                    cnt_d   = '0;
                end
                S_IX0_ACCESS: begin
                    if (done_ok) begin
                        state_d = skip1 ? S_DAT_SETUP : S_IX1_SETUP;
`ifdef BLOCK1_INDIRECT_INDEX_CACHE_EN
                        c0_valid_d = 1'b1;
                        c0_d       = index0_q;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_IX1_SETUP: begin
                    state_d = S_IX1_ACCESS;
                    cnt_d   = '0;
                end
                S_IX1_ACCESS: begin
                    if (done_ok) begin
                        state_d = S_DAT_SETUP;
`ifdef BLOCK1_INDIRECT_INDEX_CACHE_EN
                        c1_valid_d = 1'b1;
                        c1_d       = index1_q;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DAT_SETUP: begin
                    state_d = S_DAT_ACCESS;
                    cnt_d   = '0;
                end
                S_DAT_ACCESS: begin
                    if (done_ok) begin
                        state_d      = S_RESP;
                        rsp_status_d = ST_OK;
                        rsp_rdata_d  = req_write_q ? 32'h0 : bus.i_prdata;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.i_rsp_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Registered outputs decoded from the next state so APB fields are stable per transfer.
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        penable_d   = (state_d == S_IX0_ACCESS) || (state_d == S_IX1_ACCESS) ||
                      (state_d == S_DAT_ACCESS);
        psel_d      = 1'b0;
        paddr_d     = '0;
        pwrite_d    = 1'b0;
        pwdata_d    = '0;
        pstrb_d     = '0;
        case (state_d)
            S_IX0_SETUP, S_IX0_ACCESS: begin
                psel_d   = 1'b1;
                paddr_d  = IX0_ADDR;
                pwrite_d = 1'b1;
                pwdata_d = {24'h0, index0_d};
                pstrb_d  = 4'b0001;
            end
            S_IX1_SETUP, S_IX1_ACCESS: begin
                psel_d   = 1'b1;
                paddr_d  = IX1_ADDR;
                pwrite_d = 1'b1;
                pwdata_d = {24'h0, index1_d};
                pstrb_d  = 4'b0001;
            end
            S_DAT_SETUP, S_DAT_ACCESS: begin
                psel_d   = 1'b1;
                paddr_d  = DAT_ADDR;
                pwrite_d = req_write_d;
                pwdata_d = req_write_d ? wdata_d : 32'h0;
                pstrb_d  = req_write_d ? 4'hF : 4'h0;
            end
            default: begin
                psel_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            req_write_q  <= 1'b0;
            index0_q     <= '0;
            index1_q     <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_status_q <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            paddr_q      <= '0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
`ifdef BLOCK1_INDIRECT_INDEX_CACHE_EN
            c0_valid_q   <= 1'b0;
            c1_valid_q   <= 1'b0;
            c0_q         <= '0;
            c1_q         <= '0;
            skip1_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_write_q  <= req_write_d;
            index0_q     <= index0_d;
            index1_q     <= index1_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_status_q <= rsp_status_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            paddr_q      <= paddr_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
`ifdef BLOCK1_INDIRECT_INDEX_CACHE_EN
            c0_valid_q   <= c0_valid_d;
            c1_valid_q   <= c1_valid_d;
            c0_q         <= c0_d;
            c1_q         <= c1_d;
            skip1_q      <= skip1_d;
`endif
        end
    end

    assign bus.o_req_ready  = req_ready_q;
    assign bus.o_rsp_valid  = rsp_valid_q;
    assign bus.o_rsp_rdata  = rsp_rdata_q;
    assign bus.o_rsp_status = rsp_status_q;
    assign bus.o_psel       = psel_q;
    assign bus.o_penable    = penable_q;
    assign bus.o_paddr      = paddr_q;
    assign bus.o_pwrite     = pwrite_q;
    assign bus.o_pwdata     = pwdata_q;
    assign bus.o_pstrb      = pstrb_q;

endmodule

// File: tb/tb_block_1_indirect_access_ctrl.sv
// Testbench for block_1_indirect_access_ctrl: directed table, reset and cache
// sequences, then random requests checked against a transaction-level model.
module tb_block_1_indirect_access_ctrl;

    localparam int unsigned AW = 7;
    localparam int          TO = 16;

    typedef struct {
        logic        wr;
        logic [7:0]  i0;
        logic [7:0]  i1;
        logic [31:0] wd;
        logic [31:0] rd;
        int          w0, w1, w2;
        bit          e0, e1, e2;
    } req_t;

    typedef struct {
        req_t        r;
        logic [1:0]  st;
        logic [31:0] rdat;
        int          lat;
        int          ntx;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [31:0]   wd;
        logic [3:0]    strb;
        int            acc;
    } xfer_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    block_1_indirect_access_ctrl_if #(.ADDRESS_WIDTH(AW)) bus ();

    block_1_indirect_access_ctrl #(
        .ADDRESS_WIDTH(AW),
        .TIMEOUT      (TO)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int          n_vec = 0;
    int          n_mis = 0;
    xfer_t       obs_q[$];
    xfer_t       exp_q[$];
    int          cfg_w[3];
    bit          cfg_e[3];
    logic [31:0] cfg_rd;
    bit          mc_v[2];
    logic [7:0]  mc_val[2];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic int reg_sel(input logic [AW-1:0] a);
        if (a == AW'(7'h00)) return 0;
        if (a == AW'(7'h04)) return 1;
        return 2;
    endfunction

    function automatic logic [AW-1:0] addr_of(input int k);
        if (k == 0) return AW'(7'h00);
        if (k == 1) return AW'(7'h04);
        return AW'(7'h10);
    endfunction

    function automatic req_t mk(input logic wr, input logic [7:0] i0, input logic [7:0] i1,
                                input logic [31:0] wd, input logic [31:0] rd,
                                input int w0, input int w1, input int w2,
                                input bit e0, input bit e1, input bit e2);
        req_t r;
        r.wr = wr; r.i0 = i0; r.i1 = i1; r.wd = wd; r.rd = rd;
        r.w0 = w0; r.w1 = w1; r.w2 = w2; r.e0 = e0; r.e1 = e1; r.e2 = e2;
        return r;
    endfunction

    // APB slave: logs each transfer at SETUP, inserts the configured wait states
    always @(negedge clk) begin
        int k;
        int s;
        bus.i_pready  = 1'b0;
        bus.i_pslverr = 1'b0;
        bus.i_prdata  = $urandom;
        if (!rst && bus.o_psel) begin
            if (!bus.o_penable) begin
                xfer_t x;
                x.addr = bus.o_paddr; x.wr = bus.o_pwrite; x.wd = bus.o_pwdata;
                x.strb = bus.o_pstrb; x.acc = 0;
                obs_q.push_back(x);
            end else if (obs_q.size() == 0) begin
                check("apb_access_without_setup", 32'd1, 32'd0);
            end else begin
                k = obs_q.size() - 1;
                check("apb_ctrl_stable", {20'h0, 1'b0, bus.o_paddr, bus.o_pwrite, bus.o_pstrb},
                      {20'h0, 1'b0, obs_q[k].addr, obs_q[k].wr, obs_q[k].strb});
                check("apb_wdata_stable", bus.o_pwdata, obs_q[k].wd);
                s = reg_sel(obs_q[k].addr);
                if (obs_q[k].acc == cfg_w[s]) begin
                    bus.i_pready  = 1'b1;
                    bus.i_pslverr = cfg_e[s];
                    if (!cfg_e[s]) bus.i_prdata = cfg_rd;
                end
                obs_q[k].acc = obs_q[k].acc + 1;
            end
        end
    end

    // Transaction-level reference: which transfers appear, their cost, and the response
    task automatic model(input req_t r, output logic [1:0] st, output logic [31:0] rd, output int lat);
        xfer_t x;
        int    w;
        bit    e;
        bit    hit;
        exp_q.delete();
        st  = 2'b00;
        lat = 1;
        for (int k = 0; k < 3; k++) begin
            hit = 1'b0;
`ifdef BLOCK1_INDIRECT_INDEX_CACHE_EN
            if (k < 2) hit = mc_v[k] && (mc_val[k] == ((k == 0) ? r.i0 : r.i1));
`endif
            if (!hit) begin
                x.addr = addr_of(k);
                x.wr   = (k < 2) ? 1'b1 : r.wr;
                x.wd   = (k == 0) ? {24'h0, r.i0} : (k == 1) ? {24'h0, r.i1} : (r.wr ? r.wd : 32'h0);
                x.strb = (k < 2) ? 4'h1 : (r.wr ? 4'hF : 4'h0);
                w = (k == 0) ? r.w0 : (k == 1) ? r.w1 : r.w2;
                e = (k == 0) ? r.e0 : (k == 1) ? r.e1 : r.e2;
                if (w >= TO) begin
                    x.acc = TO;
                    st    = 2'b10;
                end else begin
                    x.acc = w + 1;
                    if (e) st = 2'b01;
                end
                exp_q.push_back(x);
                lat = lat + 1 + x.acc;
                if (st != 2'b00) break;
`ifdef BLOCK1_INDIRECT_INDEX_CACHE_EN
                if (k < 2) begin
                    mc_v[k]   = 1'b1;
                    mc_val[k] = (k == 0) ? r.i0 : r.i1;
                end
`endif
            end
        end
        if (st != 2'b00) begin
            mc_v[0] = 1'b0;
            mc_v[1] = 1'b0;
        end
        rd = (st == 2'b00 && !r.wr) ? r.rd : 32'h0;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus.i_req_valid  = 1'b0;
        bus.i_req_write  = 1'b0;
        bus.i_req_index0 = '0;
        bus.i_req_index1 = '0;
        bus.i_req_wdata  = '0;
        bus.i_rsp_ready  = 1'b0;
        mc_v[0] = 1'b0;
        mc_v[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_req(input req_t r);
        int g;
        cfg_w[0] = r.w0; cfg_w[1] = r.w1; cfg_w[2] = r.w2;
        cfg_e[0] = r.e0; cfg_e[1] = r.e1; cfg_e[2] = r.e2;
        cfg_rd   = r.rd;
        obs_q.delete();
        @(negedge clk);
        bus.i_req_valid  = 1'b1;
        bus.i_req_write  = r.wr;
        bus.i_req_index0 = r.i0;
        bus.i_req_index1 = r.i1;
        bus.i_req_wdata  = r.wd;
        g = 0;
        while (!bus.o_req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("req_ready_seen", 32'(bus.o_req_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic apply(input req_t r, input logic [1:0] est, input logic [31:0] erd,
                         input int elat, input int entx, input string tag);
        int          lat;
        int          h;
        bit          got;
        bit          stable;
        bit          ok;
        logic [31:0] hold_rd;
        logic [1:0]  hold_st;
        start_req(r);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            bus.i_req_valid = 1'b0;
            if (bus.o_rsp_valid) got = 1'b1;
        end
        check({tag, " rsp_valid"}, 32'(got), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(elat));
        check({tag, " status"}, 32'(bus.o_rsp_status), 32'(est));
        check({tag, " rdata"}, bus.o_rsp_rdata, erd);
        check({tag, " psel_in_resp"}, 32'(bus.o_psel), 32'd0);
        check({tag, " n_transfers"}, 32'(obs_q.size()), 32'(entx));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            ok = (obs_q[i].addr === exp_q[i].addr) && (obs_q[i].wr === exp_q[i].wr) &&
                 (obs_q[i].wd === exp_q[i].wd) && (obs_q[i].strb === exp_q[i].strb) &&
                 (obs_q[i].acc == exp_q[i].acc);
            n_vec++;
            if (!ok) begin
                n_mis++;
                $display("FAIL %s xfer%0d: got addr=%0h wr=%0b wd=%0h strb=%0h acc=%0d expected addr=%0h wr=%0b wd=%0h strb=%0h acc=%0d",
                         tag, i, obs_q[i].addr, obs_q[i].wr, obs_q[i].wd, obs_q[i].strb, obs_q[i].acc,
                         exp_q[i].addr, exp_q[i].wr, exp_q[i].wd, exp_q[i].strb, exp_q[i].acc);
            end
        end
        hold_rd = bus.o_rsp_rdata;
        hold_st = bus.o_rsp_status;
        stable  = 1'b1;
        h = $urandom_range(0, 2);
        repeat (h) begin
            @(negedge clk);
            if (!bus.o_rsp_valid || bus.o_rsp_rdata !== hold_rd || bus.o_rsp_status !== hold_st)
                stable = 1'b0;
        end
        check({tag, " rsp_hold"}, 32'(stable), 32'd1);
        bus.i_rsp_ready = 1'b1;
        @(negedge clk);
        bus.i_rsp_ready = 1'b0;
        check({tag, " rsp_dropped"}, 32'(bus.o_rsp_valid), 32'd0);
        check({tag, " next_ready"}, 32'(bus.o_req_ready), 32'd1);
    endtask

    function automatic int rand_wait();
        int p;
        p = $urandom_range(0, 19);
        if (p == 0) return TO + $urandom_range(0, 2);
        if (p < 5)  return $urandom_range(1, 4);
        return 0;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[7];
        req_t        r;
        logic [1:0]  mst;
        logic [31:0] mrd;
        int          mlat;
        int          g;
        bit          seen;

        tbl[0].r = mk(1'b1, 8'h01, 8'h00, 32'h5A, 32'h0, 0, 0, 0, 0, 0, 0);
        tbl[0].st = 2'b00; tbl[0].rdat = 32'h0;  tbl[0].lat = 7;  tbl[0].ntx = 3;
        tbl[1].r = mk(1'b0, 8'h01, 8'h01, 32'h0, 32'hA5, 0, 0, 2, 0, 0, 0);
        tbl[1].st = 2'b00; tbl[1].rdat = 32'hA5; tbl[1].lat = 9;  tbl[1].ntx = 3;
        tbl[2].r = mk(1'b1, 8'h02, 8'h03, 32'h1234, 32'h0, 0, 0, 0, 0, 1, 0);
        tbl[2].st = 2'b01; tbl[2].rdat = 32'h0;  tbl[2].lat = 5;  tbl[2].ntx = 2;
        tbl[3].r = mk(1'b0, 8'h04, 8'h05, 32'h0, 32'h77, 20, 0, 0, 0, 0, 0);
        tbl[3].st = 2'b10; tbl[3].rdat = 32'h0;  tbl[3].lat = 18; tbl[3].ntx = 1;
        tbl[4].r = mk(1'b0, 8'h06, 8'h07, 32'h0, 32'hFF, 0, 0, 0, 0, 0, 1);
        tbl[4].st = 2'b01; tbl[4].rdat = 32'h0;  tbl[4].lat = 7;  tbl[4].ntx = 3;
        tbl[5].r = mk(1'b1, 8'h08, 8'h09, 32'hDEADBEEF, 32'h0, 0, 15, 0, 0, 0, 0);
        tbl[5].st = 2'b00; tbl[5].rdat = 32'h0;  tbl[5].lat = 22; tbl[5].ntx = 3;
        tbl[6].r = mk(1'b0, 8'h0A, 8'h0B, 32'h0, 32'h1, 0, 16, 0, 0, 0, 0);
        tbl[6].st = 2'b10; tbl[6].rdat = 32'h0;  tbl[6].lat = 20; tbl[6].ntx = 2;

        // Reset state
        rst = 1'b1;
        do_reset();
        rst = 1'b1;
        @(negedge clk);
        check("reset psel", 32'(bus.o_psel), 32'd0);
        check("reset req_ready", 32'(bus.o_req_ready), 32'd0);
        check("reset rsp", {bus.o_rsp_valid, 29'h0, bus.o_rsp_status}, 32'h0);
        check("reset rdata", bus.o_rsp_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(bus.o_req_ready), 32'd1);

        // Directed table, each from a fresh reset
        for (int i = 0; i < 7; i++) begin
            do_reset();
            model(tbl[i].r, mst, mrd, mlat);
            apply(tbl[i].r, tbl[i].st, tbl[i].rdat, tbl[i].lat, tbl[i].ntx, $sformatf("tbl%0d", i));
        end

        // Reset asserted while the index1 transfer is waiting in its access phase
        do_reset();
        r = mk(1'b1, 8'h12, 8'h34, 32'h55, 32'h0, 0, 6, 0, 0, 0, 0);
        start_req(r);
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        g = 0;
        while (!(obs_q.size() == 2 && bus.o_penable) && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("mid_reset reached_ix1_access", 32'(obs_q.size() == 2 && bus.o_penable), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_reset apb_ctrl", {26'h0, bus.o_psel, bus.o_penable, bus.o_pwrite, 3'b0}, 32'h0);
        check("mid_reset paddr_strb", {21'h0, bus.o_paddr, bus.o_pstrb}, 32'h0);
        check("mid_reset pwdata", bus.o_pwdata, 32'h0);
        check("mid_reset req_rsp", {29'h0, bus.o_req_ready, bus.o_rsp_valid, 1'b0}, 32'h0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.o_rsp_valid) seen = 1'b1;
        end
        rst = 1'b0;
        mc_v[0] = 1'b0;
        mc_v[1] = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.o_rsp_valid) seen = 1'b1;
        end
        check("mid_reset no_response", 32'(seen), 32'd0);
        r = mk(1'b0, 8'h12, 8'h34, 32'h0, 32'hC0FFEE, 0, 0, 0, 0, 0, 0);
        model(r, mst, mrd, mlat);
        apply(r, 2'b00, 32'hC0FFEE, 7, 3, "after_mid_reset");

`ifdef BLOCK1_INDIRECT_INDEX_CACHE_EN
        // Cache: repeated index skips both index writes; an error forces a full reissue
        do_reset();
        r = mk(1'b1, 8'h33, 8'h44, 32'h11, 32'h0, 0, 0, 0, 0, 0, 0);
        model(r, mst, mrd, mlat);
        apply(r, 2'b00, 32'h0, 7, 3, "cache_fill");
        r = mk(1'b0, 8'h33, 8'h44, 32'h0, 32'hBEEF, 0, 0, 0, 0, 0, 0);
        model(r, mst, mrd, mlat);
        apply(r, 2'b00, 32'hBEEF, 3, 1, "cache_hit");
        r = mk(1'b1, 8'h33, 8'h44, 32'h22, 32'h0, 0, 0, 0, 0, 0, 1);
        model(r, mst, mrd, mlat);
        apply(r, 2'b01, 32'h0, 3, 1, "cache_hit_err");
        r = mk(1'b0, 8'h33, 8'h44, 32'h0, 32'h9, 0, 0, 0, 0, 0, 0);
        model(r, mst, mrd, mlat);
        apply(r, 2'b00, 32'h9, 7, 3, "cache_after_err");
        r = mk(1'b0, 8'h33, 8'h45, 32'h0, 32'h8, 0, 0, 0, 0, 0, 0);
        model(r, mst, mrd, mlat);
        apply(r, 2'b00, 32'h8, 5, 2, "cache_ix1_only");
`endif

        // Random back-to-back requests against the model
        do_reset();
        for (int n = 0; n < 40; n++) begin
            r.wr = 1'($urandom_range(0, 1));
            r.i0 = 8'($urandom_range(0, 2));
            r.i1 = 8'($urandom_range(0, 2));
            r.wd = $urandom;
            r.rd = $urandom;
            r.w0 = rand_wait();
            r.w1 = rand_wait();
            r.w2 = rand_wait();
            r.e0 = ($urandom_range(0, 11) == 0);
            r.e1 = ($urandom_range(0, 11) == 0);
            r.e2 = ($urandom_range(0, 11) == 0);
            model(r, mst, mrd, mlat);
            apply(r, mst, mrd, mlat, exp_q.size(), $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
